fm_demod_mc: RTL and testbench

Time-multiplexed, parametrised quadrature FM demodulator for CHANNELS independent I/Q streams sharing one datapath. Each accepted sample is multiplied by the conjugate of the previous sample on its channel; the phase of that product is taken from a registered arctangent lookup and emitted tagged with its channel number. It sits between the per-channel decimating I/Q filters and the audio mixer/output stage. It replaces the single-channel demodulator.

---
 rtl/fm_demod_mc.sv | 239 +++++++++++++++++++++++
 tb/tb_fm_demod_mc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fm_demod_mc.sv
// rtl/fm_demod_mc.sv - time-multiplexed multi-channel quadrature FM demodulator
// Define FM_DEMOD_DEEMPH_EN to add the per-channel de-emphasis stage (latency 4 instead of 3).
module fm_demod_mc #(
  parameter int BITS_IN      = 8,
  parameter int BITS_OUT     = 16,
  parameter int CHANNELS     = 4,
  parameter int CH_BITS      = 2,
  parameter int LUT_BITS     = 5,
  parameter int DEEMPH_SHIFT = 4
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       flush,
  input  logic signed [BITS_IN-1:0]  I_in,
  input  logic signed [BITS_IN-1:0]  Q_in,
  input  logic        [CH_BITS-1:0]  ch_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [BITS_OUT-1:0] demod_out,
  output logic        [CH_BITS-1:0]  out_ch,
  output logic                       out_valid
);
  localparam int PW       = 2 * BITS_IN + 1;
  localparam int CH_DEPTH = 1 << CH_BITS;
  localparam int LUT_SIZE = 1 << (2 * LUT_BITS);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);

  // Illegal parameter combinations leave this block elaborated; it is empty on purpose.
  if (LUT_BITS >= PW || DEEMPH_SHIFT >= BITS_OUT || CHANNELS > CH_DEPTH) begin : g_param_range_invalid
  end

  function automatic logic signed [BITS_OUT-1:0] atan_entry(input int k);
    int  ri, ii, v, vmax;
    real ang, scaled;
    ri = (k >> LUT_BITS) & ((1 << LUT_BITS) - 1);
    ii = k & ((1 << LUT_BITS) - 1);
    if (ri >= (1 << (LUT_BITS - 1))) ri = ri - (1 << LUT_BITS);
    if (ii >= (1 << (LUT_BITS - 1))) ii = ii - (1 << LUT_BITS);
    vmax = (1 << (BITS_OUT - 1)) - 1;
    if (ri == 0 && ii == 0) begin
      v = 0;
    end else begin
      ang    = $atan2(real'(ii), real'(ri));
      scaled = ang * real'(1 << (BITS_OUT - 1)) / 3.14159265358979323846;
      if (scaled >= 0.0) v = $rtoi(scaled + 0.5);
      else               v = -$rtoi(0.5 - scaled);
      if (v > vmax) v = vmax;
    end
    return BITS_OUT'(v);
  endfunction

  // Table contents are fixed at elaboration; index is {r_idx, i_idx}.
  logic signed [BITS_OUT-1:0] atan_rom [LUT_SIZE];
  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    localparam logic signed [BITS_OUT-1:0] ENTRY = atan_entry(k);
    assign atan_rom[k] = ENTRY;
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  state_e             state_q, state_d;
  logic [CH_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic               clr_we;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (flush) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      if (clr_cnt_q == LAST_CH) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  assign in_ready = (state_q == ST_RUN);

  logic acc, ch_ok;
  assign acc   = in_valid && in_ready && !flush;
  assign ch_ok = (ch_in <= LAST_CH);

  logic signed [BITS_IN-1:0] i_hist_q [CH_DEPTH];
  logic signed [BITS_IN-1:0] q_hist_q [CH_DEPTH];
  logic        [CH_DEPTH-1:0] seen_q;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int c = 0; c < CH_DEPTH; c++) begin
        i_hist_q[c] <= '0;
        q_hist_q[c] <= '0;
      end
      seen_q <= '0;
    end else if (clr_we) begin
      i_hist_q[clr_cnt_q] <= '0;
      q_hist_q[clr_cnt_q] <= '0;
      seen_q[clr_cnt_q]   <= 1'b0;
    end else if (acc && ch_ok) begin
      i_hist_q[ch_in] <= I_in;
      q_hist_q[ch_in] <= Q_in;
      seen_q[ch_in]   <= 1'b1;
    end
  end

  logic                      s0_valid_q, s0_seen_q;
  logic [CH_BITS-1:0]        s0_ch_q;
  logic signed [BITS_IN-1:0] s0_i_q, s0_q_q, s0_ip_q, s0_qp_q;
  logic                      s1_valid_q, s1_seen_q;
  logic [CH_BITS-1:0]        s1_ch_q;
  logic signed [PW-1:0]      prod_re_q, prod_im_q, prod_re_d, prod_im_d;
  logic                      s2_valid_q, s2_seen_q;
  logic [CH_BITS-1:0]        s2_ch_q;
  logic signed [BITS_OUT-1:0] ph_q, phase_x;
  logic [2*LUT_BITS-1:0]     lut_idx;
  logic signed [BITS_OUT-1:0] demod_q;
  logic [CH_BITS-1:0]        out_ch_q;
  logic                      out_valid_q;
  logic                      unused_low_bits;

  always_comb begin
    prod_re_d = PW'(s0_i_q) * PW'(s0_ip_q) + PW'(s0_q_q) * PW'(s0_qp_q);
    prod_im_d = PW'(s0_q_q) * PW'(s0_ip_q) - PW'(s0_i_q) * PW'(s0_qp_q);
  end

  assign lut_idx         = {prod_re_q[PW-1 -: LUT_BITS], prod_im_q[PW-1 -: LUT_BITS]};
  assign unused_low_bits = ^{prod_re_q[PW-LUT_BITS-1:0], prod_im_q[PW-LUT_BITS-1:0]};
  assign phase_x         = s2_seen_q ? ph_q : '0;

  // History is read before this cycle's write lands, so back-to-back samples chain correctly.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      s0_valid_q <= 1'b0; s0_seen_q <= 1'b0; s0_ch_q <= '0;
      s0_i_q <= '0; s0_q_q <= '0; s0_ip_q <= '0; s0_qp_q <= '0;
      s1_valid_q <= 1'b0; s1_seen_q <= 1'b0; s1_ch_q <= '0;
      prod_re_q <= '0; prod_im_q <= '0;
      s2_valid_q <= 1'b0; s2_seen_q <= 1'b0; s2_ch_q <= '0; ph_q <= '0;
    end else begin
      s0_valid_q <= acc && ch_ok;
      if (acc && ch_ok) begin
        s0_ch_q   <= ch_in;
        s0_i_q    <= I_in;
        s0_q_q    <= Q_in;
        s0_ip_q   <= i_hist_q[ch_in];
        s0_qp_q   <= q_hist_q[ch_in];
        s0_seen_q <= seen_q[ch_in];
      end
      s1_valid_q <= s0_valid_q && !flush;
      s1_seen_q  <= s0_seen_q;
      s1_ch_q    <= s0_ch_q;
      prod_re_q  <= prod_re_d;
      prod_im_q  <= prod_im_d;
      s2_valid_q <= s1_valid_q && !flush;
      s2_seen_q  <= s1_seen_q;
      s2_ch_q    <= s1_ch_q;
      ph_q       <= atan_rom[lut_idx];
    end
  end

`ifdef FM_DEMOD_DEEMPH_EN
  localparam int SW = BITS_OUT + DEEMPH_SHIFT;
  logic                       s3_valid_q;
  logic [CH_BITS-1:0]         s3_ch_q;
  logic signed [BITS_OUT-1:0] s3_x_q;
  logic signed [SW-1:0]       y_q [CH_DEPTH];
  logic signed [SW:0]         y_diff;
  logic signed [SW-1:0]       y_cur, y_new;

  // State carries DEEMPH_SHIFT fraction bits; x is aligned to the same scale.
  always_comb begin
    y_cur  = y_q[s3_ch_q];
    y_diff = ((SW+1)'(s3_x_q) <<< DEEMPH_SHIFT) - (SW+1)'(y_cur);
    y_new  = y_cur + SW'(y_diff >>> DEEMPH_SHIFT);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int c = 0; c < CH_DEPTH; c++) y_q[c] <= '0;
    end else if (clr_we) begin
      y_q[clr_cnt_q] <= '0;
    end else if (s3_valid_q && !flush) begin
      y_q[s3_ch_q] <= y_new;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      s3_valid_q  <= 1'b0;
      s3_ch_q     <= '0;
      s3_x_q      <= '0;
      demod_q     <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s3_valid_q  <= s2_valid_q && !flush;
      s3_ch_q     <= s2_ch_q;
      s3_x_q      <= phase_x;
      out_valid_q <= s3_valid_q && !flush;
      if (s3_valid_q) begin
        demod_q  <= y_new[SW-1 -: BITS_OUT];
        out_ch_q <= s3_ch_q;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      demod_q     <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s2_valid_q && !flush;
      if (s2_valid_q) begin
        demod_q  <= phase_x;
        out_ch_q <= s2_ch_q;
      end
    end
  end
`endif

  assign demod_out = demod_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fm_demod_mc.sv
// tb/tb_fm_demod_mc.sv - directed vector bench for fm_demod_mc
// Built with CHANNELS=4, CH_BITS=3 so out-of-range channel numbers can be presented.
module tb_fm_demod_mc;
`ifdef FM_DEMOD_DEEMPH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int NVEC = 24;

  logic               CLK = 1'b0;
  logic               RSTb = 1'b0;
  logic               flush = 1'b0;
  logic signed [7:0]  I_in = '0;
  logic signed [7:0]  Q_in = '0;
  logic        [2:0]  ch_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] demod_out;
  logic        [2:0]  out_ch;
  logic               out_valid;

  fm_demod_mc #(
    .BITS_IN(8), .BITS_OUT(16), .CHANNELS(4), .CH_BITS(3), .LUT_BITS(5), .DEEMPH_SHIFT(4)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .flush(flush), .I_in(I_in), .Q_in(Q_in), .ch_in(ch_in),
    .in_valid(in_valid), .in_ready(in_ready), .demod_out(demod_out), .out_ch(out_ch),
    .out_valid(out_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  typedef struct { logic [2:0] ch; int i; int q; bit has_out; int val; } vec_t;
  typedef struct { logic [2:0] ch; int val; int acc; } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en && out_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("demod_out", int'(demod_out), e.val);
        check("out_ch", int'(out_ch), int'(e.ch));
        check("latency", cyc - e.acc, LAT);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] ch, input int i, input int q, input bit has_out, input int val);
    exp_t e;
    check("in_ready_at_send", int'(in_ready), 1);
    ch_in    = ch;
    I_in     = 8'(i);
    Q_in     = 8'(q);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (has_out) begin
      e.ch  = ch;
      e.val = val;
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name, input int req);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check(name, n, req);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("pending_outputs", exp_q.size(), 0);
  endtask

  function automatic vec_t mk(input int ch, input int i, input int q, input int has_out, input int val);
    vec_t v;
    v.ch      = 3'(ch);
    v.i       = i;
    v.q       = q;
    v.has_out = (has_out != 0);
    v.val     = val;
    return v;
  endfunction

  initial begin
    vec_t tbl[NVEC];
    // ch0 rotates +pi/2 per sample; ch5 is out of range and must leave history alone
    tbl[0]  = mk(0,  100,    0, 1,      0);
    tbl[1]  = mk(0,    0,  100, 1,  16384);
    tbl[2]  = mk(5,   50,  -70, 0,      0);
    tbl[3]  = mk(0, -100,    0, 1,  16384);
    tbl[4]  = mk(0,    0, -100, 1,  16384);
    // interleave: ch0 +pi/2, ch1 -pi/2 each sample, ch4 dropped mid-stream
    tbl[5]  = mk(0,  100,    0, 1,  16384);
    tbl[6]  = mk(1,  100,    0, 1,      0);
    tbl[7]  = mk(0,    0,  100, 1,  16384);
    tbl[8]  = mk(1,    0, -100, 1, -16384);
    tbl[9]  = mk(4, -128,  127, 0,      0);
    tbl[10] = mk(0, -100,    0, 1,  16384);
    tbl[11] = mk(1, -100,    0, 1, -16384);
    tbl[12] = mk(0,    0, -100, 1,  16384);
    tbl[13] = mk(1,    0,  100, 1, -16384);
    // ch2: +pi saturates
    tbl[14] = mk(2,  100,    0, 1,      0);
    tbl[15] = mk(2, -100,    0, 1,  32767);
    // ch3: pi/4, small-magnitude indices, (0,0) index, atan2(-3,2)
    tbl[16] = mk(3,  100,    0, 1,      0);
    tbl[17] = mk(3,  100,  100, 1,   8192);
    tbl[18] = mk(3,    0,  100, 1,   8192);
    tbl[19] = mk(3,   10,    0, 1, -16384);
    tbl[20] = mk(3,    1,    1, 1,      0);
    tbl[21] = mk(3,  100,    0, 1, -16384);
    tbl[22] = mk(3,  100, -100, 1, -10251);
    tbl[23] = mk(1,  100,    0, 1, -16384);

    repeat (3) step();
    check("reset_demod_out", int'(demod_out), 0);
    check("reset_out_ch", int'(out_ch), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 0);

    RSTb   = 1'b1;
    mon_en = 1'b1;
    wait_ready("ready_after_reset", 4);

    for (int k = 0; k < NVEC; k++) begin
      send(tbl[k].ch, tbl[k].i, tbl[k].q, tbl[k].has_out, tbl[k].val);
    end
    drain();

    // two samples in flight when flush arrives: both must vanish
    send(3'd0, 100, 0, 1'b0, 0);
    send(3'd0, 0, 100, 1'b0, 0);
    flush = 1'b1;
    step();
    check("in_ready_after_flush", int'(in_ready), 0);
    step();
    step();
    check("in_ready_flush_held", int'(in_ready), 0);
    flush = 1'b0;
    wait_ready("ready_after_flush", 4);

    send(3'd0, 0, 100, 1'b1, 0);
    send(3'd0, -100, 0, 1'b1, 16384);
    send(3'd1, 5, 5, 1'b1, 0);
    send(3'd2, -100, 0, 1'b1, 0);
    drain();
    repeat (8) step();
    check("final_out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
